// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider producing one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to add a signed_mode input for two's complement operands.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

   logic [1:0]       state, state_nx;
   logic [WIDTH-1:0] r, q, den, a_mag, b_mag, sub, r_nx, q_nx, q_fix, r_fix, dz_quot;
   logic [WIDTH:0]   r_sh;
   logic [CW-1:0]    cnt;
   logic             ge, a_neg, b_neg, neg_q, neg_r;

`ifdef SEQ_DIVIDER_SIGNED_EN
   assign a_neg = signed_mode & dividend[WIDTH-1];
   assign b_neg = signed_mode & divisor[WIDTH-1];
   always_ff @(posedge clk)
      if (rst) {neg_q, neg_r} <= 2'b00;
      else if (state == IDLE && start) {neg_q, neg_r} <= {a_neg ^ b_neg, a_neg};
`else
   assign a_neg = 1'b0;
   assign b_neg = 1'b0;
   assign neg_q = 1'b0;
   assign neg_r = 1'b0;
`endif

   assign a_mag   = a_neg ? -dividend : dividend;
   assign b_mag   = b_neg ? -divisor : divisor;
   // x/0 gives +1 for a negative signed dividend, all ones otherwise
   assign dz_quot = a_neg ? WIDTH'(1) : '1;

   // The remainder stays below the divisor, so only the shifted value needs the extra bit.
   assign r_sh  = {r, q[WIDTH-1]};
   assign ge    = r_sh >= {1'b0, den};
   assign sub   = r_sh[WIDTH-1:0] - den;
   assign r_nx  = ge ? sub : r_sh[WIDTH-1:0];
   assign q_nx  = {q[WIDTH-2:0], ge};
   assign q_fix = neg_q ? -q_nx : q_nx;
   assign r_fix = neg_r ? -r_nx : r_nx;

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;

   always_comb
      state_nx = (state == IDLE) ? (start ? ((divisor == '0) ? DONE : RUN) : IDLE)
               : (state == RUN)  ? ((cnt == '0) ? DONE : RUN)
               : IDLE;

   always_comb begin
      busy = state != IDLE;
      done = state == DONE;
   end

   always_ff @(posedge clk)
      if (rst) begin
         r           <= '0;
         q           <= '0;
         den         <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (state == IDLE && start) begin
         r   <= '0;
         q   <= a_mag;
         den <= b_mag;
         cnt <= CW'(WIDTH - 1);
         if (divisor == '0) begin
            quotient    <= dz_quot;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         r   <= r_nx;
         q   <= q_nx;
         cnt <= cnt - CW'(1);
         if (cnt == '0) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
         end
      end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider (WIDTH=8) against an
// arithmetic reference model; signed cases run when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;
   localparam int W = 8;

   logic         clk = 0, rst, start, signed_mode;
   logic [W-1:0] dividend, divisor, quotient, remainder;
   logic         busy, done, div_by_zero;
   int           checks = 0, failures = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
      .signed_mode(signed_mode),
`endif
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference results straight from the arithmetic definition.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        output logic [W-1:0] mq, output logic [W-1:0] mr, output logic mz);
      int sa, sb;
      mz = (b == 0);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (mz) begin
         mq = (sm && sa < 0) ? 8'h01 : 8'hFF;
         mr = a;
      end else if (sm) begin
         mq = 8'(sa / sb);
         mr = 8'(sa % sb);
      end else begin
         mq = a / b;
         mr = a % b;
      end
   endtask

   // Model tracks how many busy cycles remain; the last one is the done cycle.
   int           left = 0;
   bit           armed = 0;
   logic [W-1:0] eq = 0, er = 0, tq, tr;
   logic         ez = 0, tz;

   always @(negedge clk) begin
      if (armed) begin
         chk("busy", busy, left > 0);
         chk("done", done, left == 1);
         if (left <= 1) begin
            chk("quotient", quotient, eq);
            chk("remainder", remainder, er);
            chk("div_by_zero", div_by_zero, ez);
         end
      end
      if (rst) begin
         left  <= 0;
         eq    <= 0;
         er    <= 0;
         ez    <= 0;
         armed <= 1;
      end else if (left > 0) begin
         left <= left - 1;
      end else if (start) begin
         model(dividend, divisor, signed_mode, tq, tr, tz);
         eq   <= tq;
         er   <= tr;
         ez   <= tz;
         left <= (divisor == 0) ? 1 : W + 1;
      end
   end

   // lat counts edges from the accepting edge (inclusive) to done high.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic [W-1:0] xq, input logic [W-1:0] xr, input logic xz,
                         input int lat);
      int n;
      @(posedge clk); #1 dividend = a; divisor = b; signed_mode = sm; start = 1;
      @(posedge clk); #1 start = 0;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1 n++;
      end
      chk($sformatf("latency %0d/%0d", a, b), n + 1, lat);
      chk($sformatf("lit quotient %0d/%0d", a, b), quotient, xq);
      chk($sformatf("lit remainder %0d/%0d", a, b), remainder, xr);
      chk($sformatf("lit div_by_zero %0d/%0d", a, b), div_by_zero, xz);
      @(posedge clk); #1;
   endtask

   initial begin
      int n, last;
      rst = 1; start = 0; dividend = 0; divisor = 0; signed_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset quotient", quotient, 0);
      chk("reset remainder", remainder, 0);
      chk("reset div_by_zero", div_by_zero, 0);
      rst = 0;

      run_op(20, 10, 0, 2, 0, 0, 9);
      run_op(50, 20, 0, 2, 10, 0, 9);
      run_op(15, 4, 0, 3, 3, 0, 9);
      run_op(0, 7, 0, 0, 0, 0, 9);
      run_op(255, 1, 0, 255, 0, 0, 9);
      run_op(9, 0, 0, 8'hFF, 9, 1, 1);
      run_op(15, 4, 0, 3, 3, 0, 9);

      // starts during RUN and DONE are ignored
      @(posedge clk); #1 dividend = 200; divisor = 7; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (2) @(posedge clk);
      #1 dividend = 6; divisor = 3; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("ignore done", done, 1);
      chk("ignore quotient", quotient, 28);
      chk("ignore remainder", remainder, 4);
      start = 1;
      @(posedge clk); #1 start = 0;
      chk("ignore back to idle", busy, 0);
      run_op(6, 3, 0, 2, 0, 0, 9);

      // reset in the middle of RUN discards the operation
      @(posedge clk); #1 dividend = 100; divisor = 3; start = 1;
      @(posedge clk); #1 start = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      chk("midrst quotient", quotient, 0);
      chk("midrst remainder", remainder, 0);
      repeat (12) @(posedge clk);
      #1 run_op(100, 3, 0, 33, 1, 0, 9);

      // held start re-triggers every WIDTH+2 cycles
      dividend = 50; divisor = 20; start = 1; n = 0; last = -1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done) begin
            if (last >= 0) chk("held spacing", i - last, W + 2);
            chk("held quotient", quotient, 2);
            chk("held remainder", remainder, 10);
            last = i;
            n++;
         end
      end
      start = 0;
      chk("held done count", n, 3);
      repeat (12) @(posedge clk);

      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 2) == 0);
         dividend = 8'($urandom);
         divisor = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         rst = ($urandom_range(0, 149) == 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
         signed_mode = 1'($urandom_range(0, 1));
`endif
      end
      @(posedge clk); #1 rst = 0; start = 0; signed_mode = 0;
      repeat (12) @(posedge clk);

`ifdef SEQ_DIVIDER_SIGNED_EN
      run_op(8'hF9, 8'd2, 1, 8'hFD, 8'hFF, 0, 9);
      run_op(8'd7, 8'hFE, 1, 8'hFD, 8'd1, 0, 9);
      run_op(8'h80, 8'hFF, 1, 8'h80, 8'd0, 0, 9);
      run_op(8'hF9, 8'd0, 1, 8'h01, 8'hF9, 1, 1);
      run_op(8'hF9, 8'd2, 0, 8'd124, 8'd1, 0, 9);
`endif

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
